input_conditioner: RTL
======================

Name: input_conditioner

Overview:
- Upstream front end for the traffic light controller. Takes raw pushbutton and switch lines (sensor, walk_request, reprogram, reset button) from the board pins.
- Produces clean, debounced levels plus single-cycle edge pulses. These feed the controller's synchronizer and walk-request inputs.
- Per-channel logic is a two-flop synchronizer followed by a stability counter. The counter is clocked by a shared prescaled sample tick.

Parameters:
- N_CH, 4, number of independent input channels
- TICK_DIV, 1000, clk cycles per sample tick (>=1; 1 means sample every cycle)
- STABLE_COUNT, 8, consecutive differing ticks required before level_out changes (>=1)
- HOLD_COUNT, 200, ticks level_out must stay high before long_press fires (feature only; >=1)

Ports:
- clk, input, 1, system clock
- reset, input, 1, synchronous, active-low reset
- raw_in, input, N_CH, asynchronous raw pin levels, active-high
- level_out, output, N_CH, debounced level per channel
- rise_pulse, output, N_CH, one-cycle pulse when level_out goes 0->1
- fall_pulse, output, N_CH, one-cycle pulse when level_out goes 1->0
- long_press, output, N_CH, one-cycle pulse on sustained press (0 when feature is compiled out)

Behaviour:
- Reset:
  - Applies on a clk edge while reset==0.
  - Clears the sync flops, tick counter, stability counters, hold counters, level_out, rise_pulse, fall_pulse and long_press to 0.
  - Reset itself never generates a pulse.
  - Reset mid-count discards all progress; counting restarts from 0 after release.
- Synchronizer: s1<=raw_in, s2<=s1 per channel. Only s2 is used downstream.
- Tick generator:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle where tick_cnt==TICK_DIV-1.
  - With TICK_DIV==1, tick is constantly 1.
- Per channel, evaluated only on cycles where tick=1:
  - s2==level: cnt<=0.
  - s2!=level and cnt<STABLE_COUNT-1: cnt<=cnt+1.
  - s2!=level and cnt==STABLE_COUNT-1: level<=s2, cnt<=0.
- Glitch rejection: any tick with s2==level before threshold resets cnt, so the change is rejected.
- Pulses:
  - rise_pulse/fall_pulse are registered in the same edge that updates level, and are high exactly one cycle.
  - They are 0 on all other cycles, including non-tick cycles.
- Latency:
  - With TICK_DIV=1, level_out changes STABLE_COUNT+2 edges after raw_in changes.
  - In general it is 2 edges plus STABLE_COUNT ticks, i.e. at most 2+STABLE_COUNT*TICK_DIV cycles.
- Width rules:
  - tick_cnt width is clog2(TICK_DIV), minimum 1.
  - cnt width is clog2(STABLE_COUNT), minimum 1.
  - Counters never exceed their terminal value.
- Channels are fully independent. Simultaneous edges on several channels produce simultaneous pulses.
- rise and fall are never both high on the same channel in the same cycle.

Optional Feature:
- Macro INPUT_CONDITIONER_LONG_PRESS_EN.
- Defined:
  - Each channel has a hold counter, incremented on ticks while level==1.
  - When the hold counter reaches HOLD_COUNT-1 on a tick, long_press pulses for one cycle.
  - The counter then saturates, so there is one pulse per press.
  - The counter clears to 0 whenever level==0 or on reset.
- Undefined: long_press is tied to 0, no hold counters are synthesized, and the port list is unchanged.

Decomposition:
- Shared package (traffic_pkg) holds:
  - Channel index constants CH_SENSOR=0, CH_WALK=1, CH_PROG=2, CH_RESET=3.
  - Default TICK_DIV and STABLE_COUNT values.
  - A clog2-based width helper.
- Sub-module debounce_channel:
  - Contains the sync flops, stability counter, level, edge pulses and optional hold counter for one channel.
  - Instantiated N_CH times in a generate loop.
  - The tick generator lives once in input_conditioner and is shared by all channels.

Test Plan:
- TICK_DIV=1, STABLE_COUNT=3, reset held low 3 cycles -> all outputs 0 during reset and the cycle after release.
- raw_in[0] 0->1 held -> level_out[0]=1 at edge 5 after change; rise_pulse[0] high exactly one cycle; other channels stay 0.
- raw_in[1] pulsed high for 2 cycles then low -> level_out[1] stays 0; no rise_pulse or fall_pulse.
- TICK_DIV=4, STABLE_COUNT=2: raw_in[2] 0->1 held -> level_out[2] rises within 2+8 cycles, only on a tick cycle; later 1->0 gives a single fall_pulse[2].
- Counting in progress on raw_in[3] (cnt==2); assert reset one cycle -> outputs 0; after release, the full STABLE_COUNT+2 latency applies again.
- With INPUT_CONDITIONER_LONG_PRESS_EN defined, HOLD_COUNT=5, TICK_DIV=1: hold raw_in[0] high 20 cycles -> exactly one long_press[0] pulse 5 cycles after level_out rises. Without the macro -> long_press stays 0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller front end:
// channel indices, default timing parameters and a counter width helper.
package traffic_pkg;

   localparam int unsigned CH_SENSOR = 0;
   localparam int unsigned CH_WALK   = 1;
   localparam int unsigned CH_PROG   = 2;
   localparam int unsigned CH_RESET  = 3;

   localparam int unsigned DEF_N_CH         = 4;
   localparam int unsigned DEF_TICK_DIV     = 1000;
   localparam int unsigned DEF_STABLE_COUNT = 8;
   localparam int unsigned DEF_HOLD_COUNT   = 200;

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// debounce_channel: two-flop synchronizer, tick-driven stability counter,
// registered level with one-cycle rise/fall pulses.
// Optional sustained-press detector enabled by INPUT_CONDITIONER_LONG_PRESS_EN.
module debounce_channel
   import traffic_pkg::*;
#(
   parameter int unsigned STABLE_COUNT = DEF_STABLE_COUNT
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
   , parameter int unsigned HOLD_COUNT = DEF_HOLD_COUNT
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic raw_in,
   output logic level_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic long_press
);

   localparam int unsigned CW = width_of(STABLE_COUNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

   logic          s1_q, s1_d;
   logic          s2_q, s2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   // Synchronize, then accept a new level only after STABLE_COUNT differing ticks.
   always_comb begin
      s1_d    = raw_in;
      s2_d    = s1_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (tick) begin
         if (s2_q == level_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = s2_q;
            rise_d  = s2_q;
            fall_d  = ~s2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Debounce state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_out  = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
   // Counter parks at HOLD_COUNT, one past the firing value, so each press fires once.
   localparam int unsigned HW = width_of(HOLD_COUNT + 1);

   logic [HW-1:0] hold_q, hold_d;
   logic          long_q, long_d;

   // Count ticks while the debounced level is high; fire on the HOLD_COUNT-th.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (!level_q) begin
         hold_d = '0;
      end else if (tick && (hold_q != HW'(HOLD_COUNT))) begin
         hold_d = hold_q + HW'(1);
         long_d = (hold_q == HW'(HOLD_COUNT - 1));
      end
   end

   // Hold counter and long-press pulse registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_press = long_q;
`else
   assign long_press = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounces N_CH raw board inputs into clean levels and
// one-cycle edge pulses, using a single shared sample-tick prescaler.
// Macro INPUT_CONDITIONER_LONG_PRESS_EN enables per-channel long_press.
module input_conditioner
   import traffic_pkg::*;
#(
   parameter int unsigned N_CH         = DEF_N_CH,
   parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
   parameter int unsigned STABLE_COUNT = DEF_STABLE_COUNT
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
   , parameter int unsigned HOLD_COUNT = DEF_HOLD_COUNT
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] raw_in,
   output logic [N_CH-1:0] level_out,
   output logic [N_CH-1:0] rise_pulse,
   output logic [N_CH-1:0] fall_pulse,
   output logic [N_CH-1:0] long_press
);

   localparam int unsigned TW = width_of(TICK_DIV);

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick;

   // Tick on the last count of each TICK_DIV period, then wrap.
   always_comb begin
      tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
   end

   // Prescaler register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_COUNT (STABLE_COUNT)
`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
         , .HOLD_COUNT (HOLD_COUNT)
`endif
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .tick       (tick),
         .raw_in     (raw_in[i]),
         .level_out  (level_out[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i]),
         .long_press (long_press[i])
      );
   end

endmodule
